// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the instruction fetch queue and its buffer.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } state_t;

    localparam logic [15:0] NOP_IR      = 16'h0000;
    localparam int          PC_STEP_DEF = 4;

    typedef struct packed {
        logic [15:0] ir;
        logic [15:0] pcplus4;
    } entry_t;

endpackage

// File: rtl/fetch_queue_fifo.sv
// DEPTH-entry circular buffer of fetched instructions, updated on the falling clock edge.
// Head is visible the edge after push; flush beats push and pop, and a pop lets a push land even when full.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
)(
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   i_flush,
    input  logic                   i_push,
    input  entry_t                 i_push_dat,
    input  logic                   i_pop,
    output entry_t                 o_head,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    entry_t          r_mem [DEPTH];
    logic [AW-1:0]   r_rd_ptr;
    logic [AW-1:0]   r_wr_ptr;
    logic [CW-1:0]   r_count;
    logic            w_push;
    logic            w_pop;

    assign w_pop  = i_pop && (r_count != '0);
    assign w_push = i_push && ((r_count != CW'(DEPTH)) || w_pop);

    always_ff @(negedge clock) begin
        if (w_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch ahead of IF/ID: one outstanding imem request, DEPTH-entry buffer, redirect flush.
// Data reaches ID one edge after ack; stall holds the head. FETCH_QUEUE_BYPASS_EN forwards ack data to an empty queue's output.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          PC_STEP  = PC_STEP_DEF
)(
    input  logic                   clock,
    input  logic                   reset,
    output logic                   imem_req,
    output logic [15:0]            imem_addr,
    input  logic                   imem_ack,
    input  logic [15:0]            imem_rdata,
    input  logic                   redirect,
    input  logic [15:0]            redirect_pc,
    input  logic                   stall,
    output logic                   out_valid,
    output logic [15:0]            out_ir,
    output logic [15:0]            out_pcplus4,
    output logic [15:0]            fetch_pc,
    output logic [$clog2(DEPTH):0] count
);
    localparam int          CW   = $clog2(DEPTH) + 1;
    localparam logic [15:0] STEP = 16'(PC_STEP);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [15:0]     r_fetch_pc;
    logic [15:0]     w_fetch_pc_nxt;
    logic [15:0]     r_addr;
    logic [15:0]     w_addr_nxt;
    logic            w_ack_live;
    logic            w_bypass;
    logic            w_push;
    logic            w_pop;
    entry_t          w_push_dat;
    entry_t          w_head;
    logic [CW-1:0]   w_count;

    assign w_ack_live = (r_state == REQ) && imem_ack && !redirect;
    assign w_push_dat = '{ir: imem_rdata, pcplus4: r_addr + STEP};

`ifdef FETCH_QUEUE_BYPASS_EN
    assign w_bypass = w_ack_live && (w_count == '0);
`else
    assign w_bypass = 1'b0;
`endif

    // A bypassed word that ID accepts this cycle never occupies a slot.
    assign w_push = w_ack_live && !(w_bypass && !stall);
    assign w_pop  = (w_count != '0) && !redirect && !stall;

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .i_flush    (redirect),
        .i_push     (w_push),
        .i_push_dat (w_push_dat),
        .i_pop      (w_pop),
        .o_head     (w_head),
        .o_count    (w_count)
    );

    always_comb begin
        w_state_nxt    = r_state;
        w_fetch_pc_nxt = r_fetch_pc;
        w_addr_nxt     = r_addr;
        unique case (r_state)
            IDLE: begin
                if (redirect) begin
                    w_fetch_pc_nxt = redirect_pc;
                end else if (w_count < FULL) begin
                    w_state_nxt = REQ;
                    w_addr_nxt  = r_fetch_pc;
                end
            end
            REQ: begin
                if (redirect) begin
                    w_fetch_pc_nxt = redirect_pc;
                    w_state_nxt    = imem_ack ? IDLE : DROP;
                end else if (imem_ack) begin
                    w_fetch_pc_nxt = r_fetch_pc + STEP;
                    // Pops are ignored here, so a re-issue always has a guaranteed slot.
                    if ((w_count + CW'(w_push)) < FULL) begin
                        w_addr_nxt = r_fetch_pc + STEP;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            DROP: begin
                if (redirect) begin
                    w_fetch_pc_nxt = redirect_pc;
                end
                if (imem_ack) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_fetch_pc <= RESET_PC;
            r_addr     <= RESET_PC;
        end else begin
            r_state    <= w_state_nxt;
            r_fetch_pc <= w_fetch_pc_nxt;
            r_addr     <= w_addr_nxt;
        end
    end

    always_comb begin
        out_valid   = 1'b0;
        out_ir      = NOP_IR;
        out_pcplus4 = '0;
        if ((w_count != '0) && !redirect) begin
            out_valid   = 1'b1;
            out_ir      = w_head.ir;
            out_pcplus4 = w_head.pcplus4;
        end else if (w_bypass) begin
            out_valid   = 1'b1;
            out_ir      = w_push_dat.ir;
            out_pcplus4 = w_push_dat.pcplus4;
        end
    end

    assign imem_req  = (r_state != IDLE);
    assign imem_addr = r_addr;
    assign fetch_pc  = r_fetch_pc;
    assign count     = w_count;

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized bench for fetch_queue against a queue-based reference model and a variable-latency memory.
module tb_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [15:0] RESET_PC = 16'h0000;
    localparam logic [15:0] STEP     = 16'd4;
`ifdef FETCH_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct packed {
        logic [15:0] ir;
        logic [15:0] pc4;
    } ment_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        stall;
    logic        out_valid;
    logic [15:0] out_ir;
    logic [15:0] out_pcplus4;
    logic [15:0] fetch_pc;
    logic [2:0]  count;

    fetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC),
        .PC_STEP  (4)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .stall       (stall),
        .out_valid   (out_valid),
        .out_ir      (out_ir),
        .out_pcplus4 (out_pcplus4),
        .fetch_pc    (fetch_pc),
        .count       (count)
    );

    initial forever #5 clock = ~clock;

    int          n_checks = 0;
    int          n_errors = 0;

    // Reference model: buffered instructions plus the outstanding-request view.
    ment_t       mq[$];
    bit          m_busy;
    bit          m_drop;
    logic [15:0] m_addr;
    logic [15:0] m_fpc;

    int          mem_cnt;
    int          mem_lat;
    int          lat_max;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        logic [15:0] h;
        h = a * 16'd40503;
        return h ^ 16'h1D2B;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_busy  = 1'b0;
        m_drop  = 1'b0;
        m_addr  = RESET_PC;
        m_fpc   = RESET_PC;
        mem_cnt = 0;
        mem_lat = 0;
    endtask

    task automatic step_cycle(input bit st, input bit rd, input logic [15:0] rpc);
        int          sz;
        bit          byp;
        bit          pop;
        bit          push;
        bit          exp_valid;
        logic [15:0] exp_ir;
        logic [15:0] exp_pc4;
        ment_t       e;

        @(posedge clock);
        stall       = st;
        redirect    = rd;
        redirect_pc = rpc;
        imem_ack    = imem_req && (mem_cnt >= mem_lat);
        imem_rdata  = mem_word(imem_addr);
        #1;

        sz  = mq.size();
        byp = BYP && (sz == 0) && m_busy && !m_drop && imem_ack && !rd;
        exp_valid = ((sz != 0) && !rd) || byp;
        exp_ir    = 16'h0000;
        exp_pc4   = 16'h0000;
        if ((sz != 0) && !rd) begin
            exp_ir  = mq[0].ir;
            exp_pc4 = mq[0].pc4;
        end else if (byp) begin
            exp_ir  = imem_rdata;
            exp_pc4 = m_addr + STEP;
        end

        check_eq("imem_req",    32'(imem_req),    32'(m_busy));
        check_eq("imem_addr",   32'(imem_addr),   32'(m_addr));
        check_eq("fetch_pc",    32'(fetch_pc),    32'(m_fpc));
        check_eq("count",       32'(count),       32'(sz));
        check_eq("out_valid",   32'(out_valid),   32'(exp_valid));
        check_eq("out_ir",      32'(out_ir),      32'(exp_ir));
        check_eq("out_pcplus4", 32'(out_pcplus4), 32'(exp_pc4));

        if (rd) begin
            mq.delete();
            m_fpc = rpc;
            if (m_busy) begin
                if (imem_ack) begin
                    m_busy = 1'b0;
                    m_drop = 1'b0;
                end else begin
                    m_drop = 1'b1;
                end
            end
        end else begin
            pop  = (sz != 0) && !st;
            push = 1'b0;
            if (m_busy && imem_ack) begin
                if (m_drop) begin
                    m_busy = 1'b0;
                    m_drop = 1'b0;
                end else begin
                    push  = !(byp && !st);
                    e     = '{ir: imem_rdata, pc4: m_addr + STEP};
                    m_fpc = m_addr + STEP;
                    if (sz + int'(push) < DEPTH) m_addr = m_fpc;
                    else m_busy = 1'b0;
                end
            end else if (!m_busy && sz < DEPTH) begin
                m_busy = 1'b1;
                m_addr = m_fpc;
            end
            if (pop) void'(mq.pop_front());
            if (push) mq.push_back(e);
        end

        if (imem_req && !imem_ack) begin
            mem_cnt++;
        end else begin
            mem_cnt = 0;
            mem_lat = $urandom_range(0, lat_max);
        end
        @(negedge clock);
    endtask

    function automatic logic [15:0] rand_pc();
        logic [13:0] w;
        if ($urandom_range(0, 3) == 0) return 16'hFFFC;
        w = 14'($urandom_range(0, 16383));
        return {w, 2'b00};
    endfunction

    initial begin
        reset       = 1'b1;
        imem_ack    = 1'b0;
        imem_rdata  = 16'h0000;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        stall       = 1'b0;
        lat_max     = 0;
        model_reset();

        #12;
        check_eq("rst_imem_req",    32'(imem_req),    32'd0);
        check_eq("rst_imem_addr",   32'(imem_addr),   32'(RESET_PC));
        check_eq("rst_fetch_pc",    32'(fetch_pc),    32'(RESET_PC));
        check_eq("rst_count",       32'(count),       32'd0);
        check_eq("rst_out_valid",   32'(out_valid),   32'd0);
        check_eq("rst_out_ir",      32'(out_ir),      32'd0);
        check_eq("rst_out_pcplus4", 32'(out_pcplus4), 32'd0);
        #1 reset = 1'b0;

        // Zero-wait streaming, then a 6-cycle stall to fill the queue.
        for (int i = 0; i < 20; i++) step_cycle(1'b0, 1'b0, 16'h0000);
        for (int i = 0; i < 6; i++)  step_cycle(1'b1, 1'b0, 16'h0000);
        for (int i = 0; i < 12; i++) step_cycle(1'b0, 1'b0, 16'h0000);

        // Partially filled queue, then a redirect to 0x0024.
        for (int i = 0; i < 3; i++)  step_cycle(1'b1, 1'b0, 16'h0000);
        step_cycle(1'b1, 1'b1, 16'h0024);
        for (int i = 0; i < 8; i++)  step_cycle(1'b0, 1'b0, 16'h0000);

        // Address wrap at the top of the 16-bit space.
        step_cycle(1'b0, 1'b1, 16'hFFFC);
        for (int i = 0; i < 6; i++)  step_cycle(1'b0, 1'b0, 16'h0000);

        // Slow memory with redirects landing in wait cycles.
        lat_max = 3;
        for (int i = 0; i < 2500; i++) begin
            step_cycle($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 7, rand_pc());
        end

        // Asynchronous reset while a request is outstanding.
        for (int i = 0; i < 20 && !(m_busy && mem_lat > 0); i++) begin
            step_cycle(1'b0, 1'b0, 16'h0000);
        end
        @(posedge clock);
        #2 reset = 1'b1;
        #1;
        check_eq("arst_imem_req",  32'(imem_req),  32'd0);
        check_eq("arst_out_valid", 32'(out_valid), 32'd0);
        check_eq("arst_count",     32'(count),     32'd0);
        check_eq("arst_fetch_pc",  32'(fetch_pc),  32'(RESET_PC));
        imem_ack = 1'b0;
        stall    = 1'b0;
        redirect = 1'b0;
        model_reset();
        @(negedge clock);
        #3 reset = 1'b0;

        for (int i = 0; i < 600; i++) begin
            step_cycle($urandom_range(0, 99) < 40, $urandom_range(0, 99) < 5, rand_pc());
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction prefetch stage directly upstream of the IF/ID pipeline register.
- Issues requests to a variable-latency instruction memory and buffers the returned 16-bit instructions, each with its PC+4, in a small FIFO.
- Presents one instruction per cycle to ID.
- Inserts nop (16'h0000) when empty or stalled, and flushes on branch redirect from EX/MEM.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- RESET_PC, 16'h0000, first fetch address after reset.
- PC_STEP, 4, byte increment per instruction; word index is pc>>2.

Ports:
- clock  in  1  pipeline clock; all state updates on negedge clock, matching the pipeline registers.
- reset  in  1  asynchronous, active-high.
- imem_req  out  1  request to instruction memory.
- imem_addr  out  16  byte address of the request.
- imem_ack  in  1  data valid for the outstanding request.
- imem_rdata  in  16  instruction word.
- redirect  in  1  taken branch; flush the queue.
- redirect_pc  in  16  new fetch address.
- stall  in  1  ID cannot accept this cycle.
- out_valid  out  1  out_ir is a real fetched instruction.
- out_ir  out  16  instruction to IF/ID; 16'h0000 when !out_valid.
- out_pcplus4  out  16  PC+PC_STEP of out_ir; 0 when !out_valid.
- fetch_pc  out  16  address of the next request to issue.
- count  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset values: fetch_pc=RESET_PC; FIFO empty; count=0; state IDLE; imem_req=0; imem_addr=RESET_PC; out_valid=0; out_ir=0; out_pcplus4=0.
- FSM states: IDLE, REQ, DROP. Only one request is outstanding at a time.
- IDLE:
  - If !redirect and (count + 0) < DEPTH: go to REQ, latch imem_addr=fetch_pc, assert imem_req.
  - Otherwise stay in IDLE.
- REQ:
  - imem_req stays high and imem_addr stays stable until imem_ack.
  - On ack without redirect: push {imem_rdata, imem_addr+PC_STEP}; fetch_pc += PC_STEP (16-bit wrap, 16'hFFFC → 16'h0000).
  - If space remains after the push, re-issue next cycle (REQ→REQ with a new address on the same edge). Otherwise go to IDLE.
- DROP:
  - Entered when redirect arrives while in REQ without a same-cycle ack.
  - Keeps imem_req high and the old address until ack, then discards the data and goes to IDLE.
- Redirect priority (highest first): reset > redirect > ack/push > pop.
  - On redirect the FIFO is emptied (count=0) and fetch_pc=redirect_pc.
  - Any same-cycle pop or ack data is discarded.
  - An ack in the same cycle as redirect completes the old request: REQ→IDLE.
- Output side:
  - out_valid = (count != 0) & !redirect.
  - out_ir and out_pcplus4 come from the FIFO head; 16'h0000 and 0 when !out_valid.
  - Pop occurs when out_valid & !stall.
  - While stall is high, the head is held, out_valid stays high, and no pop occurs.
- Simultaneous push and pop when full: allowed, count unchanged.
- Push when full cannot occur, because a request is only issued when a free slot is guaranteed (count < DEPTH at issue, with the pop-side never decreasing the free-slot estimate).
- Latency: redirect at edge n → request to redirect_pc asserted after edge n+1 (IDLE) or after the ack that ends DROP. With a 0-wait memory (ack in the first REQ cycle), the first instruction is valid at out_ir one edge after the ack.
- Reset asserted mid-request: imem_req drops immediately (asynchronous); the memory model must tolerate an abandoned request.

Optional Feature:
- Macro: FETCH_QUEUE_BYPASS_EN.
- Defined:
  - When count==0, state REQ, imem_ack=1 and !redirect, out_valid is driven combinationally with out_ir=imem_rdata and out_pcplus4=imem_addr+PC_STEP.
  - If !stall the word is consumed and not pushed. If stall, it is pushed normally.
  - Saves one cycle of fetch latency.
- Undefined: data always passes through the FIFO (minimum one-edge latency).

Decomposition:
- Package fetch_pkg holds:
  - state enum {IDLE, REQ, DROP};
  - NOP_IR = 16'h0000;
  - entry struct {ir[15:0], pcplus4[15:0]};
  - PC_STEP default.
- One sub-module: fetch_fifo.
  - Synchronous DEPTH-entry circular buffer with push, pop, flush, count, and head outputs.
  - Flush has priority over push and pop.

Test Plan:
- Reset, memory with 0-wait ack, stall=0 → out_ir sequence equals IMemory[0], [1], [2] with out_pcplus4 = 4, 8, 12; one instruction per cycle after fill.
- stall=1 held for 6 cycles with 0-wait memory → count saturates at 4, imem_req stays low while full, out_ir holds IMemory[0]; after release, 4 instructions follow with no gap or loss.
- redirect with redirect_pc=16'h0024 while count=3 and no request outstanding → same edge count=0, out_ir=0; next requests are addresses 0x0024, 0x0028; out_pcplus4=0x0028.
- Memory with 3-cycle ack latency, redirect in the 2nd wait cycle → state DROP, imem_addr is the old address until ack; the returned word never appears at out_ir; the next request is to redirect_pc.
- redirect and imem_ack in the same cycle → ack data discarded, FSM to IDLE, then a request to redirect_pc; fetch_pc at 16'hFFFC followed by an ack → wraps to 16'h0000.
- With FETCH_QUEUE_BYPASS_EN, empty queue, 0-wait ack, stall=0 → out_valid in the ack cycle with out_ir=imem_rdata and count remains 0; without the macro, out_valid appears one cycle later.
